// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the multi-digit up/down counter.
//   bcd_digit_t  : one packed BCD digit
//   BCD_MAX      : largest legal digit value
//   bcd_sanitise : maps an illegal digit (>9) to 0
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
        return (d > BCD_MAX) ? bcd_digit_t'(0) : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down counter.
// Ports:
//   clk        : system clock, rising edge
//   sync_clr_n : synchronous active-low clear
//   load       : store load_digit (sanitised) this edge
//   load_digit : digit value to load
//   step_en    : advance this digit by one (carry/borrow from lower digits)
//   up_down    : 1 = increment, 0 = decrement
//   hold       : suppress stepping (saturate at global terminal count)
//   digit      : registered digit value
//   at_limit   : digit is 9 when counting up, 0 when counting down
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       sync_clr_n,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step_en,
    input  logic       up_down,
    input  logic       hold,
    output logic [3:0] digit,
    output logic       at_limit
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_sanitise(load_digit);
        end else if (step_en && !hold) begin
            if (up_down) begin
                digit_d = (digit_q == BCD_MAX) ? bcd_digit_t'(0) : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_clr_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit    = digit_q;
    assign at_limit = up_down ? (digit_q == BCD_MAX) : (digit_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with parallel load and
// wrap/saturate behaviour at terminal count.
// Ports:
//   clk          : system clock, rising edge
//   sync_clr_n   : synchronous active-low reset
//   count_enable : advance count by one this cycle
//   up_down      : 1 = count up, 0 = count down
//   load         : parallel load of load_value (priority over count_enable)
//   load_value   : packed BCD digits, [3:0] = digit 0
//   digits       : registered packed BCD count, [3:0] = digit 0
//   roll_over    : combinational lookahead terminal-count flag, for cascading
//   load_err     : one-cycle pulse after a load containing a digit > 9
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int WRAP_MODE  = 1
) (
    input  logic                    clk,
    input  logic                    sync_clr_n,
    input  logic                    count_enable,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    roll_over,
    output logic                    load_err
);

    logic [NUM_DIGITS-1:0] at_limit;
    logic [NUM_DIGITS-1:0] step_en;
    logic                  all_limit;
    logic                  hold;
    logic                  any_bad;
    logic                  load_err_q;
    logic                  load_err_d;

    // Digit k steps only when every lower digit is at its limit
    // (ripple carry when counting up, ripple borrow when counting down).
    always_comb begin
        step_en[0] = count_enable;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            step_en[i] = step_en[i-1] & at_limit[i-1];
        end
    end

    assign all_limit = &at_limit;

    // Saturating counters freeze every digit at the global terminal count.
    assign hold = (WRAP_MODE == 0) && all_limit;

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk        (clk),
                .sync_clr_n (sync_clr_n),
                .load       (load),
                .load_digit (load_value[4*g +: 4]),
                .step_en    (step_en[g]),
                .up_down    (up_down),
                .hold       (hold),
                .digit      (digits[4*g +: 4]),
                .at_limit   (at_limit[g])
            );
        end
    endgenerate

    always_comb begin
        any_bad = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (load_value[4*i +: 4] > BCD_MAX) begin
                any_bad = 1'b1;
            end
        end
        load_err_d = load & any_bad;
    end

    always_ff @(posedge clk) begin
        if (!sync_clr_n) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;

    // Masked by reset so a cascaded stage never sees a spurious enable.
    assign roll_over = sync_clr_n & count_enable & ~load & all_limit;

endmodule
